// File: rtl/sr_latch_drv_pkg.sv
// ============================================================================
// Module   : sr_latch_drv_pkg
// Brief    : Shared state encoding, parameter defaults and sizing helper for
//            the SR latch driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_latch_drv_pkg;

    localparam int DEF_PULSE_CYCLES  = 4;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_MAX_RETRY     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for one asynchronous input, resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_latch_driver.sv
// ============================================================================
// Module   : sr_latch_driver
// Brief    : Pulses S or R of an external latch, waits, verifies Q/Qbar
//            feedback and retries a bounded number of times.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_driver
    import sr_latch_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_state
);

    localparam int PW = cnt_width(PULSE_CYCLES - 1);
    localparam int SW = cnt_width(SETTLE_CYCLES - 1);
    localparam int RW = cnt_width(MAX_RETRY);

    localparam logic [PW-1:0] c_pulse_last  = PW'(PULSE_CYCLES - 1);
    localparam logic [SW-1:0] c_settle_last = SW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] c_retry_max   = RW'(MAX_RETRY);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pcnt, w_pcnt_nxt;
    logic [SW-1:0] r_scnt, w_scnt_nxt;
    logic [RW-1:0] r_retry, w_retry_nxt;
    logic          r_cmd, w_cmd_nxt;
    logic          w_done_nxt, w_err_nxt, w_qstate_nxt;
    logic          w_q_sync, w_qb_sync;
    logic          w_accept, w_pass;

    sync_2ff u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (q_fb),
        .o_q   (w_q_sync)
    );

    sync_2ff u_sync_qb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (qbar_fb),
        .o_q   (w_qb_sync)
    );

    assign w_accept = cmd_valid & cmd_ready;
    assign w_pass   = (w_q_sync == r_cmd) & (w_qb_sync == ~r_cmd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pcnt_nxt   = r_pcnt;
        w_scnt_nxt   = r_scnt;
        w_retry_nxt  = r_retry;
        w_cmd_nxt    = r_cmd;
        w_done_nxt   = 1'b0;
        w_err_nxt    = err;
        w_qstate_nxt = q_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cmd_nxt   = cmd_set;
                    w_retry_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_pcnt_nxt  = '0;
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_pcnt == c_pulse_last) begin
                    w_scnt_nxt  = '0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_pcnt_nxt = r_pcnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_scnt == c_settle_last) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_scnt_nxt = r_scnt + 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_pass) begin
                    w_done_nxt   = 1'b1;
                    w_qstate_nxt = r_cmd;
                    w_state_nxt  = ST_IDLE;
                end else if (r_retry < c_retry_max) begin
                    w_retry_nxt = r_retry + 1'b1;
                    w_pcnt_nxt  = '0;
                    w_state_nxt = ST_PULSE;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Drives and handshake flags are registered from the next state so they
    // line up with the state they describe; drives only change via IDLE or
    // a retry of the same command, so S and R can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt    <= '0;
            r_scnt    <= '0;
            r_retry   <= '0;
            r_cmd     <= 1'b0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            q_state   <= 1'b0;
        end else begin
            r_pcnt    <= w_pcnt_nxt;
            r_scnt    <= w_scnt_nxt;
            r_retry   <= w_retry_nxt;
            r_cmd     <= w_cmd_nxt;
            s_out     <= (w_state_nxt == ST_PULSE) & w_cmd_nxt;
            r_out     <= (w_state_nxt == ST_PULSE) & ~w_cmd_nxt;
            busy      <= (w_state_nxt != ST_IDLE);
            cmd_ready <= (w_state_nxt == ST_IDLE);
            done      <= w_done_nxt;
            err       <= w_err_nxt;
            q_state   <= w_qstate_nxt;
        end
    end

endmodule

`default_nettype wire
